// File: rtl/sdp_y_inp_arb_pkg.sv
// Shared types and constants for the SDP Y-inp input channel arbiter.
package sdp_y_inp_arb_pkg;

  localparam int unsigned SDP_Y_INP_PD_W  = 740;
  localparam int unsigned SDP_Y_INP_CNT_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  typedef logic src_id_t;

  localparam src_id_t SRC_MAIN   = 1'b0;
  localparam src_id_t SRC_BYPASS = 1'b1;

  // A lone candidate wins outright; a tie goes to the source not served last.
  function automatic src_id_t rr_pick(input logic [1:0] cand, input src_id_t rr_ptr);
    src_id_t pick;
    case (cand)
      2'b01:   pick = SRC_MAIN;
      2'b10:   pick = SRC_BYPASS;
      default: pick = ~rr_ptr;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/sdp_y_inp_chn_oreg.sv
// One-entry output register: holds a beat stable until the core loads it.
module sdp_y_inp_chn_oreg
  import sdp_y_inp_arb_pkg::*;
#(
  parameter int unsigned WIDTH = SDP_Y_INP_PD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] pd,
  input  logic             lz,
  output logic [WIDTH-1:0] z,
  output logic             vz,
  output logic             out_free
);

  // A new beat may enter when the slot is empty or is being drained this cycle.
  assign out_free = !vz || lz;

  always_ff @(posedge clk) begin
    if (rst) begin
      z  <= '0;
      vz <= 1'b0;
    end else if (load_en) begin
      z  <= pd;
      vz <= 1'b1;
    end else if (lz) begin
      vz <= 1'b0;
    end
  end

endmodule

// File: rtl/sdp_y_inp_chn_inp_arb.sv
// Packet-locked two-source round-robin arbiter feeding the Y-inp core input channel.
module sdp_y_inp_chn_inp_arb
  import sdp_y_inp_arb_pkg::*;
#(
  parameter int unsigned WIDTH = SDP_Y_INP_PD_W,
  parameter int unsigned CNT_W = SDP_Y_INP_CNT_W
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [WIDTH-1:0] src0_pd,
  input  logic             src0_vld,
  input  logic             src0_last,
  output logic             src0_rdy,
  input  logic [WIDTH-1:0] src1_pd,
  input  logic             src1_vld,
  input  logic             src1_last,
  output logic             src1_rdy,
  input  logic [1:0]       cfg_src_en,
  output logic [WIDTH-1:0] chn_inp_in_rsc_z,
  output logic             chn_inp_in_rsc_vz,
  input  logic             chn_inp_in_rsc_lz,
  output logic             arb_busy,
  output logic             arb_owner,
  output logic [CNT_W-1:0] beat_cnt
);

  arb_state_t       state;
  src_id_t          rr_ptr;
  src_id_t          owner;
  src_id_t          gsel;
  logic             grant_vld;
  logic [1:0]       cand;
  logic             out_free;
  logic             accept;
  logic             sel_last;
  logic [WIDTH-1:0] sel_pd;

  // Grant: round-robin among enabled valid sources in IDLE, owner only in LOCK.
  always_comb begin
    cand      = {src1_vld, src0_vld} & cfg_src_en;
    gsel      = rr_pick(cand, rr_ptr);
    grant_vld = |cand;
    if (state == ARB_LOCK) begin
      gsel      = owner;
      grant_vld = 1'b1;
    end
  end

  assign src0_rdy = !nvdla_core_rst && out_free && grant_vld && (gsel == SRC_MAIN);
  assign src1_rdy = !nvdla_core_rst && out_free && grant_vld && (gsel == SRC_BYPASS);
  assign accept   = (src0_vld && src0_rdy) || (src1_vld && src1_rdy);
  assign sel_last = (gsel == SRC_BYPASS) ? src1_last : src0_last;
  assign sel_pd   = (gsel == SRC_BYPASS) ? src1_pd   : src0_pd;

  sdp_y_inp_chn_oreg #(
    .WIDTH (WIDTH)
  ) u_oreg (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .load_en  (accept),
    .pd       (sel_pd),
    .lz       (chn_inp_in_rsc_lz),
    .z        (chn_inp_in_rsc_z),
    .vz       (chn_inp_in_rsc_vz),
    .out_free (out_free)
  );

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= SRC_BYPASS;
      owner    <= SRC_MAIN;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        owner <= gsel;
        if (sel_last) begin
          state  <= ARB_IDLE;
          rr_ptr <= gsel;
        end else begin
          state  <= ARB_LOCK;
        end
      end
      if (chn_inp_in_rsc_vz && chn_inp_in_rsc_lz) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  assign arb_busy  = (state == ARB_LOCK);
  assign arb_owner = owner;

endmodule

// File: tb/tb_sdp_y_inp_chn_inp_arb.sv
// Directed bench for the Y-inp input channel arbiter (counter narrowed to 4 bits for wrap).
module tb_sdp_y_inp_chn_inp_arb;

  localparam int unsigned W  = 740;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s0_pd, s1_pd;
  logic          s0_vld, s0_last, s1_vld, s1_last;
  logic          s0_rdy, s1_rdy;
  logic [1:0]    en;
  logic [W-1:0]  z;
  logic          vz;
  logic          lz;
  logic          busy, owner;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdp_y_inp_chn_inp_arb #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .src0_pd           (s0_pd),
    .src0_vld          (s0_vld),
    .src0_last         (s0_last),
    .src0_rdy          (s0_rdy),
    .src1_pd           (s1_pd),
    .src1_vld          (s1_vld),
    .src1_last         (s1_last),
    .src1_rdy          (s1_rdy),
    .cfg_src_en        (en),
    .chn_inp_in_rsc_z  (z),
    .chn_inp_in_rsc_vz (vz),
    .chn_inp_in_rsc_lz (lz),
    .arb_busy          (busy),
    .arb_owner         (owner),
    .beat_cnt          (cnt)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic [1:0] exp);
    #1;
    chk(tag, W'({s1_rdy, s0_rdy}), W'(exp));
  endtask

  initial begin
    rst = 1'b1; en = 2'b11; lz = 1'b1;
    s0_vld = 1'b1; s0_last = 1'b1; s0_pd = W'(64'hA0);
    s1_vld = 1'b1; s1_last = 1'b1; s1_pd = W'(64'hB0);

    // reset with both sources valid
    chk_rdy("rst_rdy", 2'b00);
    tick(); tick();
    chk("rst_vz",    W'(vz),    W'(1'b0));
    chk("rst_z",     z,         W'(0));
    chk("rst_cnt",   W'(cnt),   W'(0));
    chk("rst_busy",  W'(busy),  W'(1'b0));
    chk("rst_owner", W'(owner), W'(1'b0));

    // tie round-robin, single-beat packets
    rst = 1'b0; s0_pd = W'(64'hA1); s1_pd = W'(64'hB1);
    chk_rdy("rr_rdy0", 2'b01);
    tick();
    chk("rr_z0", z, W'(64'hA1));
    chk("rr_vz0", W'(vz), W'(1'b1));
    chk("rr_cnt0", W'(cnt), W'(0));
    chk_rdy("rr_rdy1", 2'b10);
    tick();
    chk("rr_z1", z, W'(64'hB1));
    chk("rr_owner1", W'(owner), W'(1'b1));
    chk("rr_cnt1", W'(cnt), W'(1));
    s0_pd = W'(64'hA2);
    chk_rdy("rr_rdy2", 2'b01);
    tick();
    chk("rr_z2", z, W'(64'hA2));
    chk("rr_cnt2", W'(cnt), W'(2));
    s1_pd = W'(64'hB2);
    chk_rdy("rr_rdy3", 2'b10);
    tick();
    chk("rr_z3", z, W'(64'hB2));
    s0_vld = 1'b0; s1_vld = 1'b0;
    tick();
    chk("rr_cnt4", W'(cnt), W'(4));
    chk("rr_vz_drain", W'(vz), W'(1'b0));

    // packet lock: source 0 three beats, source 1 waiting
    s0_vld = 1'b1; s0_last = 1'b0; s0_pd = W'(64'hC1);
    s1_vld = 1'b1; s1_last = 1'b1; s1_pd = W'(64'hD1);
    chk_rdy("lk_rdy1", 2'b01);
    tick();
    chk("lk_busy1", W'(busy), W'(1'b1));
    chk("lk_z1", z, W'(64'hC1));
    s0_pd = W'(64'hC2);
    chk_rdy("lk_rdy2", 2'b01);
    tick();
    chk("lk_z2", z, W'(64'hC2));
    chk("lk_cnt2", W'(cnt), W'(5));
    s0_pd = W'(64'hC3); s0_last = 1'b1;
    chk_rdy("lk_rdy3", 2'b01);
    tick();
    chk("lk_busy3", W'(busy), W'(1'b0));
    chk("lk_z3", z, W'(64'hC3));
    chk_rdy("lk_rdy4", 2'b10);
    tick();
    chk("lk_z4", z, W'(64'hD1));
    chk("lk_vz4", W'(vz), W'(1'b1));
    chk("lk_cnt4", W'(cnt), W'(7));
    chk("lk_owner4", W'(owner), W'(1'b1));

    // backpressure: lz low for 5 cycles
    lz = 1'b0; s0_pd = W'(64'hE0);
    for (int i = 0; i < 5; i++) begin
      chk_rdy("bp_rdy", 2'b00);
      tick();
      chk("bp_z", z, W'(64'hD1));
      chk("bp_vz", W'(vz), W'(1'b1));
      chk("bp_cnt", W'(cnt), W'(7));
    end
    s0_vld = 1'b0; s1_vld = 1'b0; lz = 1'b1;
    tick();
    chk("bp_cnt_one", W'(cnt), W'(8));
    chk("bp_vz_one", W'(vz), W'(1'b0));
    lz = 1'b0;
    tick();
    chk("bp_cnt_hold", W'(cnt), W'(8));
    lz = 1'b1;

    // enable mask, then mask cleared mid-packet
    en = 2'b01;
    s0_vld = 1'b1; s0_last = 1'b0; s0_pd = W'(64'hF1);
    s1_vld = 1'b1; s1_pd = W'(64'h91);
    chk_rdy("en_rdy1", 2'b01);
    tick();
    chk("en_busy1", W'(busy), W'(1'b1));
    chk("en_z1", z, W'(64'hF1));
    en = 2'b00; s0_pd = W'(64'hF2);
    chk_rdy("en_rdy2", 2'b01);
    tick();
    chk("en_z2", z, W'(64'hF2));
    s0_last = 1'b1; s0_pd = W'(64'hF3);
    chk_rdy("en_rdy3", 2'b01);
    tick();
    chk("en_busy3", W'(busy), W'(1'b0));
    chk("en_cnt3", W'(cnt), W'(10));
    chk_rdy("en_rdy_none", 2'b00);
    tick();
    chk("en_vz_none", W'(vz), W'(1'b0));
    chk("en_cnt_none", W'(cnt), W'(11));

    // counter wrap: 17 transfers from a fresh reset
    rst = 1'b1;
    tick(); tick();
    chk("wr_cnt_rst", W'(cnt), W'(0));
    rst = 1'b0; en = 2'b11; s1_vld = 1'b0; s0_vld = 1'b1; s0_last = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      s0_pd = W'(i);
      tick();
      if (i == 16) chk("wr_cnt15", W'(cnt), W'(15));
      if (i == 17) chk("wr_cnt_wrap", W'(cnt), W'(0));
    end
    chk("wr_z17", z, W'(17));
    s0_vld = 1'b0;
    tick();
    chk("wr_cnt1", W'(cnt), W'(1));

    // reset in the middle of a locked packet
    s0_vld = 1'b1; s0_last = 1'b0; s0_pd = W'(64'h71);
    tick();
    chk("mr_busy", W'(busy), W'(1'b1));
    chk("mr_vz", W'(vz), W'(1'b1));
    rst = 1'b1;
    chk_rdy("mr_rdy_rst", 2'b00);
    tick();
    chk("mr_busy_rst", W'(busy), W'(1'b0));
    chk("mr_vz_rst", W'(vz), W'(1'b0));
    rst = 1'b0; s0_last = 1'b1; s1_vld = 1'b1; s1_last = 1'b1;
    chk_rdy("mr_rr_reset", 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
